// File: rtl/e1_s2p.sv
// e1_s2p: packs SEQ_CNT read-data beats (beat 0 in LSBs) into one wide word behind a valid/ready output register.
module e1_s2p #(
    parameter int SEQ_CNT        = 5,
    parameter int APP_DATA_WIDTH = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [APP_DATA_WIDTH-1:0]           seq,
    input  logic                                seq_valid,
    input  logic                                seq_last,
    output logic [APP_DATA_WIDTH*SEQ_CNT-1:0]   par,
    output logic                                par_valid,
    input  logic                                par_rdy,
    output logic                                overflow,
    output logic                                frame_err
);
    localparam int CW = $clog2(SEQ_CNT);
    localparam int PW = APP_DATA_WIDTH * SEQ_CNT;
    logic [CW-1:0] cnt;
    logic [PW-1:0] asm_q;
    logic [PW-1:0] word;
    logic          done;
    logic          take;
    // the final beat bypasses the assembly register so completion costs no cycle
    always_comb begin
        word = asm_q;
        word[(SEQ_CNT-1)*APP_DATA_WIDTH +: APP_DATA_WIDTH] = seq;
    end
    assign done = seq_valid && cnt == CW'(SEQ_CNT-1);
    assign take = !par_valid || par_rdy;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            asm_q     <= '0;
            par       <= '0;
            par_valid <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (seq_valid) asm_q[cnt*APP_DATA_WIDTH +: APP_DATA_WIDTH] <= seq;
            if (done) begin
                cnt <= '0;
                if (!seq_last) frame_err <= 1'b1;
                if (take) begin
                    par       <= word;
                    par_valid <= 1'b1;
                end else begin
                    overflow  <= 1'b1;
                end
            end else begin
                if (par_valid && par_rdy) par_valid <= 1'b0;
                if (seq_valid && seq_last) begin
                    cnt       <= '0;
                    frame_err <= 1'b1;
                end else if (seq_valid) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_e1_s2p.sv
// tb_e1_s2p: directed and random stimulus for e1_s2p, checked every cycle against a beat-queue reference model.
module tb_e1_s2p;
    localparam int N = 5;
    localparam int W = 64;
    logic clk = 1'b0;
    logic rst = 1'b1, seq_valid = 1'b0, seq_last = 1'b0, par_rdy = 1'b0;
    logic [W-1:0] seq = '0;
    logic [N*W-1:0] par;
    logic par_valid, overflow, frame_err;
    int total = 0, bad = 0;

    logic [W-1:0] q[$];
    logic [N*W-1:0] m_par = '0;
    logic m_pv = 1'b0, m_ov = 1'b0, m_fe = 1'b0;

    e1_s2p #(.SEQ_CNT(N), .APP_DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .seq(seq), .seq_valid(seq_valid), .seq_last(seq_last),
        .par(par), .par_valid(par_valid), .par_rdy(par_rdy),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference: a word is simply the first N beats seen since the last frame boundary
    task automatic model(input logic v, input logic l, input logic [W-1:0] d, input logic r, input logic rs);
        logic [N*W-1:0] w;
        logic completed;
        completed = 1'b0;
        if (rs) begin
            q.delete();
            m_par = '0; m_pv = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
        end else begin
            if (v) begin
                q.push_back(d);
                if (q.size() == N) begin
                    completed = 1'b1;
                    for (int k = 0; k < N; k++) w[k*W +: W] = q[k];
                    q.delete();
                    if (!l) m_fe = 1'b1;
                    if (!m_pv || r) begin
                        m_par = w;
                        m_pv = 1'b1;
                    end else m_ov = 1'b1;
                end else if (l) begin
                    m_fe = 1'b1;
                    q.delete();
                end
            end
            if (!completed && m_pv && r) m_pv = 1'b0;
        end
    endtask

    task automatic cyc(input logic v, input logic l, input logic [W-1:0] d, input logic r, input logic rs);
        seq_valid = v; seq_last = l; seq = d; par_rdy = r; rst = rs;
        @(posedge clk);
        model(v, l, d, r, rs);
        #1;
        chk("par", par, m_par);
        chk("par_valid", {{(N*W-1){1'b0}}, par_valid}, {{(N*W-1){1'b0}}, m_pv});
        chk("overflow", {{(N*W-1){1'b0}}, overflow}, {{(N*W-1){1'b0}}, m_ov});
        chk("frame_err", {{(N*W-1){1'b0}}, frame_err}, {{(N*W-1){1'b0}}, m_fe});
    endtask

    task automatic idle(input logic r);
        cyc(1'b0, 1'b0, '0, r, 1'b0);
    endtask

    task automatic send_word(input logic [N*W-1:0] w, input logic r, input logic r_last);
        for (int k = 0; k < N; k++)
            cyc(1'b1, k == N-1, w[k*W +: W], (k == N-1) ? r_last : r, 1'b0);
    endtask

    function automatic logic [N*W-1:0] rand_word();
        logic [N*W-1:0] w;
        for (int k = 0; k < N; k++) w[k*W +: W] = {$urandom, $urandom};
        return w;
    endfunction

    initial begin
        logic [N*W-1:0] w10, a, b, c;
        logic v, l;
        for (int k = 0; k < N; k++) w10[k*W +: W] = W'(16 + k);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("rst_par", par, '0);
        chk("rst_flags", {{(N*W-3){1'b0}}, par_valid, overflow, frame_err}, '0);

        send_word(w10, 1'b1, 1'b1);
        chk("w10_par", par, w10);
        chk("w10_valid", {{(N*W-1){1'b0}}, par_valid}, 1);
        idle(1'b1);
        chk("w10_consumed", {{(N*W-1){1'b0}}, par_valid}, 0);

        for (int k = 0; k < N; k++) begin
            repeat ($urandom_range(0, 3)) idle(1'b0);
            cyc(1'b1, k == N-1, w10[k*W +: W], 1'b0, 1'b0);
        end
        chk("gap_par", par, w10);
        chk("gap_valid", {{(N*W-1){1'b0}}, par_valid}, 1);
        idle(1'b1);

        a = rand_word(); b = rand_word();
        send_word(a, 1'b0, 1'b0);
        send_word(b, 1'b0, 1'b0);
        chk("ovf_par", par, a);
        chk("ovf_flag", {{(N*W-1){1'b0}}, overflow}, 1);
        idle(1'b1);
        chk("ovf_drain", {{(N*W-1){1'b0}}, par_valid}, 0);
        chk("ovf_keep", par, a);

        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        a = rand_word(); b = rand_word();
        send_word(a, 1'b0, 1'b0);
        send_word(b, 1'b0, 1'b1);
        chk("swap_par", par, b);
        chk("swap_flags", {{(N*W-2){1'b0}}, par_valid, overflow}, 2);
        idle(1'b1);

        c = rand_word();
        for (int k = 0; k < 3; k++) cyc(1'b1, k == 2, {$urandom, $urandom}, 1'b0, 1'b0);
        chk("short_none", {{(N*W-1){1'b0}}, par_valid}, 0);
        chk("short_ferr", {{(N*W-1){1'b0}}, frame_err}, 1);
        send_word(c, 1'b0, 1'b0);
        chk("c_par", par, c);
        idle(1'b1);

        a = rand_word(); b = rand_word();
        send_word(a, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, b[0 +: W], 1'b0, 1'b0);
        cyc(1'b1, 1'b0, b[W +: W], 1'b0, 1'b0);
        cyc(1'b1, 1'b0, b[2*W +: W], 1'b0, 1'b1);
        chk("mrst_par", par, '0);
        chk("mrst_flags", {{(N*W-3){1'b0}}, par_valid, overflow, frame_err}, '0);
        c = rand_word();
        send_word(c, 1'b1, 1'b1);
        chk("post_rst_par", par, c);
        idle(1'b1);

        for (int i = 0; i < 600; i++) begin
            v = $urandom_range(0, 3) != 0;
            l = v && ((q.size() == N-1) ? $urandom_range(0, 9) != 0 : $urandom_range(0, 24) == 0);
            cyc(v, l, {$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/e1_s2p.md
# e1_s2p

Serial-to-parallel collector for the memory read-data path. It accepts one `APP_DATA_WIDTH` read-data beat per cycle from the memory controller user interface and packs `SEQ_CNT` beats into one wide word. It presents that word to the application through a valid/ready handshake. It sits between the controller's `app_rd_data*` outputs and the downstream consumer, and packs beats in the same beat-0-in-LSBs order the write path uses to unpack them.

## Interface
- `SEQ_CNT`, default 5: beats per wide word; must be ≥ 2.
- `APP_DATA_WIDTH`, default 64: width of one beat.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `seq`  in  `APP_DATA_WIDTH`  read-data beat (`app_rd_data`).
- `seq_valid`  in  1  beat valid (`app_rd_data_valid`); cannot be back-pressured.
- `seq_last`  in  1  controller end-of-burst marker (`app_rd_data_end`); sampled only when `seq_valid` = 1.
- `par`  out  `APP_DATA_WIDTH*SEQ_CNT`  assembled word; beat k occupies `[k*APP_DATA_WIDTH +: APP_DATA_WIDTH]`.
- `par_valid`  out  1  `par` holds an undelivered word.
- `par_rdy`  in  1  consumer accepts `par` when `par_valid & par_rdy`.
- `overflow`  out  1  sticky; set when a completed word is dropped.
- `frame_err`  out  1  sticky; set on a `seq_last` / beat-count mismatch.

## Operation
- Beat counter `cnt`, width `$clog2(SEQ_CNT)`, range 0..`SEQ_CNT`-1. It advances only on `seq_valid`. Gaps with `seq_valid` = 0 are allowed anywhere and hold all state.
- Assembly register: on `seq_valid`, slice `cnt` of the assembly register is written with `seq`.
- Completion is `seq_valid & (cnt == SEQ_CNT-1)`. On completion, `cnt` returns to 0 and the full word is transferred to the output register. The transferred word is the first `SEQ_CNT-1` stored beats plus the current `seq`, which is bypassed so no extra cycle is spent.
- Output register load rule: the word loads if `par_valid` = 0, or if `par_valid & par_rdy` in the same cycle. After the load, `par_valid` = 1.
- Otherwise the completed word is discarded. `par` and `par_valid` are unchanged and `overflow` is set to 1.
- Consume without completion: if `par_valid & par_rdy` and no completion occurs, `par_valid` drops to 0. `par` keeps its old value.
- Early `seq_last` (`seq_valid & seq_last` with `cnt != SEQ_CNT-1`):
  - `frame_err` is set to 1 and `cnt` resyncs to 0.
  - The partial word, including the current beat, is discarded; nothing is delivered.
- Missing `seq_last` (completion with `seq_last` = 0): `frame_err` is set to 1 and the word is still delivered normally.
- `overflow` and `frame_err` clear only on `rst`.
- The assembly register is not cleared between words. Every slice is overwritten before it is used.

## Timing
- Reset values:
  - Outputs: `par` = 0, `par_valid` = 0, `overflow` = 0, `frame_err` = 0.
  - Internal: `cnt` = 0, assembly register = 0.
- Latency: `par_valid` rises on the edge that samples the last beat. It is visible in the cycle after the last beat is presented.
- Throughput: one word per `SEQ_CNT` valid beats. With back-to-back beats, the consumer has `SEQ_CNT` cycles to accept before the next word would overflow.
- Simultaneous completion and consume: the new word replaces the old one, and `par_valid` stays 1 with no bubble.
- `rst` asserted mid-frame: the partial word is lost, `cnt` = 0, and a pending undelivered word is lost. The first beat after reset deasserts is beat 0.
- `par_rdy` is ignored while `par_valid` = 0.
- Combinational paths: no input-to-output path is combinational; all outputs are registered.

## Test plan
- Reset, then five back-to-back beats `0x10..0x14` with `seq_last` on beat 4, `par_rdy` = 1 → `par_valid` = 1 for one cycle and `par` = `{0x14,0x13,0x12,0x11,0x10}` (beat 0 in LSBs); `overflow` = `frame_err` = 0.
- The same five beats with `seq_valid` gaps of 0–3 random cycles → identical `par`, with `par_valid` one cycle after the last beat.
- Hold `par_rdy` = 0 and send two full words A then B → `par` stays A and `par_valid` stays 1; `overflow` = 1 after B's last beat. Raising `par_rdy` delivers A only.
- `par_rdy` asserted in exactly the cycle B completes → A is consumed, B loads, `par_valid` stays 1, and `overflow` = 0.
- Send three beats with `seq_last` on beat 2, then a clean 5-beat word C → no delivery for the short frame, `frame_err` = 1, and C is delivered intact.
- Assert `rst` after beat 2 of a word with a pending undelivered word → all outputs return to 0. A following clean word is delivered correctly.
